// File: rtl/gate_chk_pkg.sv
// Shared constants, state encoding and expected truth table for the gate sweep checker.
package gate_chk_pkg;

  localparam int unsigned AND_B  = 0;
  localparam int unsigned OR_B   = 1;
  localparam int unsigned NAND_B = 2;
  localparam int unsigned NOR_B  = 3;
  localparam int unsigned XOR_B  = 4;
  localparam int unsigned XNOR_B = 5;

  localparam int unsigned NUM_GATES  = 6;
  localparam int unsigned NUM_COMBOS = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE
  } state_t;

  // Ideal six-gate response for one (a, b) input pair.
  function automatic logic [NUM_GATES-1:0] gate_vec(input logic a, input logic b);
    logic [NUM_GATES-1:0] v;
    v         = '0;
    v[AND_B]  = a & b;
    v[OR_B]   = a | b;
    v[NAND_B] = ~(a & b);
    v[NOR_B]  = ~(a | b);
    v[XOR_B]  = a ^ b;
    v[XNOR_B] = ~(a ^ b);
    return v;
  endfunction

  // Indexed by c = {a, b}; evaluates to 2C, 16, 16, 23 for c = 0..3.
  localparam logic [NUM_COMBOS-1:0][NUM_GATES-1:0] EXPECT_TAB = {
    gate_vec(1'b1, 1'b1),
    gate_vec(1'b1, 1'b0),
    gate_vec(1'b0, 1'b1),
    gate_vec(1'b0, 1'b0)
  };

endpackage

// File: rtl/gate_sweep_checker_expect.sv
// Combinational lookup of the expected gate vector for combination index c.
import gate_chk_pkg::*;

module gate_expect (
  input  logic [1:0]           c,
  output logic [NUM_GATES-1:0] vec_c
);

  assign vec_c = EXPECT_TAB[c];

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all four (a, b) combinations into the gate block, waits a settle time,
// and compares the six gate outputs against the ideal truth table.
import gate_chk_pkg::*;

module gate_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  a_out,
  output logic                  b_out,
  input  logic [NUM_GATES-1:0]  gate_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_GATES-1:0]  err_mask,
  output logic [NUM_COMBOS-1:0] fail_combo
);

  if ((SETTLE_CYCLES == 0) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("gate_sweep_checker: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [1:0]            c, c_nxt;
  logic                  busy_nxt, done_nxt, pass_nxt;
  logic [NUM_GATES-1:0]  err_nxt;
  logic [NUM_COMBOS-1:0] fail_nxt;
  logic [NUM_GATES-1:0]  exp_vec, mism;

  gate_expect u_expect (
    .c     (c),
    .vec_c (exp_vec)
  );

  assign mism  = gate_in ^ exp_vec;
  // Combination index register directly drives the gate block inputs.
  assign a_out = c[1];
  assign b_out = c[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      c          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_mask   <= '0;
      fail_combo <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      c          <= c_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_mask   <= err_nxt;
      fail_combo <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    c_nxt     = c;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    err_nxt   = err_mask;
    fail_nxt  = fail_combo;

    case (state)
      ST_IDLE: begin
        if (start) begin
          err_nxt   = '0;
          fail_nxt  = '0;
          pass_nxt  = 1'b0;
          c_nxt     = 2'd0;
          busy_nxt  = 1'b1;
          cnt_nxt   = SETTLE_LD;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        err_nxt = err_mask | mism;
        if (|mism) begin
          fail_nxt[c] = 1'b1;
        end
        if (c != 2'd3) begin
          c_nxt     = c + 2'd1;
          cnt_nxt   = SETTLE_LD;
          state_nxt = ST_WAIT;
        end else begin
          c_nxt     = 2'd0;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          pass_nxt  = ~|(err_mask | mism);
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: two checker instances (settle 1 and 3) driven by behavioural gate models.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic       a1, b1, busy1, done1, pass1;
  logic       a3, b3, busy3, done3, pass3;
  logic [5:0] err1, err3, gin1, gin3;
  logic [3:0] fail1, fail3;
  logic [5:0] fault1 = 6'h00;
  int         delay3 = 0;
  logic [1:0] hist [8] = '{default: 2'b00};
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    int unsigned cyc;
    logic        pass;
    logic [5:0]  err;
    logic [3:0]  fail;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit order: and, or, nand, nor, xor, xnor from bit 0 upwards.
  function automatic logic [5:0] gate_fn(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  assign gin1 = gate_fn(a1, b1) & ~fault1;

  always @(posedge clk) begin
    hist[0] <= {a3, b3};
    for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    logic [1:0] h;
    h = {a3, b3};
    if (delay3 > 0) h = hist[delay3-1];
    gin3 = gate_fn(h[1], h[0]);
  end

  gate_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
    .gate_in(gin1), .busy(busy1), .done(done1), .pass(pass1),
    .err_mask(err1), .fail_combo(fail1)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_out(a3), .b_out(b3),
    .gate_in(gin3), .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(err3), .fail_combo(fail3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int sel, input int unsigned c, input logic p,
                          input logic [5:0] e, input logic [3:0] f);
    exp_t x;
    x.cyc = c; x.pass = p; x.err = e; x.fail = f;
    if (sel == 1) q1.push_back(x);
    else q3.push_back(x);
  endtask

  // Single-cycle start; accepting edge is cyc+1, done 4*(S+1) edges later.
  task automatic launch(input int sel, input logic p, input logic [5:0] e, input logic [3:0] f);
    @(negedge clk);
    if (sel == 1) begin
      start1 = 1'b1;
      push_exp(1, cyc + 1 + 8, p, e, f);
    end else begin
      start3 = 1'b1;
      push_exp(3, cyc + 1 + 16, p, e, f);
    end
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if ((sel == 1 && done1) || (sel == 3 && done3)) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_done%0d: got no done expected done within 200 cycles", sel);
    end
  endtask

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1_done_cycle", cyc, e1.cyc);
        check("dut1_pass", pass1, e1.pass);
        check("dut1_err_mask", err1, e1.err);
        check("dut1_fail_combo", fail1, e1.fail);
        check("dut1_busy_at_done", busy1, 1'b0);
      end
    end
    if (done3) begin
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut3_unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e3 = q3.pop_front();
        check("dut3_done_cycle", cyc, e3.cyc);
        check("dut3_pass", pass3, e3.pass);
        check("dut3_err_mask", err3, e3.err);
        check("dut3_fail_combo", fail3, e3.fail);
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a", a1, 1'b0);
    check("rst_b", b1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_pass", pass1, 1'b0);
    check("rst_err_mask", err1, 6'h00);
    check("rst_fail_combo", fail1, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden sweep: ab steps 00,01,10,11 with two cycles each.
    launch(1, 1'b1, 6'h00, 4'h0);
    check("golden_busy_rise", busy1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("golden_ab", {a1, b1}, 32'(i / 2));
      if (i < 7) @(negedge clk);
    end
    wait_done(1);
    check("golden_ab_idle", {a1, b1}, 2'b00);

    // Stuck-at-0 xor, plus an ignored re-pulse of start mid-sweep.
    repeat (2) @(negedge clk);
    fault1 = 6'h10;
    launch(1, 1'b0, 6'h10, 4'h6);
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1);

    // Start held high through the done cycle: back-to-back sweeps.
    repeat (2) @(negedge clk);
    start1 = 1'b1;
    push_exp(1, cyc + 1 + 8, 1'b0, 6'h10, 4'h6);
    wait_done(1);
    fault1 = 6'h00;
    push_exp(1, cyc + 1 + 8, 1'b1, 6'h00, 4'h0);
    @(negedge clk);
    start1 = 1'b0;
    check("b2b_err_cleared", err1, 6'h00);
    check("b2b_fail_cleared", fail1, 4'h0);
    check("b2b_busy", busy1, 1'b1);
    wait_done(1);

    // Reset during combination 2 aborts the sweep.
    repeat (2) @(negedge clk);
    launch(1, 1'b1, 6'h00, 4'h0);
    repeat (4) @(negedge clk);
    check("midrst_pre_ab", {a1, b1}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ab", {a1, b1}, 2'b00);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_done", done1, 1'b0);
    check("midrst_pass", pass1, 1'b0);
    check("midrst_err_mask", err1, 6'h00);
    check("midrst_fail_combo", fail1, 4'h0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    launch(1, 1'b1, 6'h00, 4'h0);
    wait_done(1);

    // Settle window with SETTLE_CYCLES = 3.
    delay3 = 2;
    launch(3, 1'b1, 6'h00, 4'h0);
    wait_done(3);
    repeat (10) @(negedge clk);
    delay3 = 4;
    launch(3, 1'b0, 6'h3F, 4'hA);
    wait_done(3);

    repeat (3) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential sweep-and-check stage wrapped around the two-input mux-realised gate block. On a start pulse it drives all four (a, b) combinations into the gate block and waits a programmable settle time. It then samples the six gate outputs and compares them against the expected truth table. It reports per-gate and per-combination mismatches plus an overall pass flag, for on-board self-test of the gate realisations.

## Interface
- SETTLE_CYCLES, 1: cycles each combination is held before sampling; legal range 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  sweep request; accepted only when not busy
- a_out  out  1  drives gate block input a
- b_out  out  1  drives gate block input b
- gate_in  in  6  gate block outputs, bit 0 = and, bit 1 = or, bit 2 = nand, bit 3 = nor, bit 4 = xor, bit 5 = xnor
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  last sweep had zero mismatches; valid from done, held until next accepted start
- err_mask  out  6  sticky per-gate mismatch flags, same bit order as gate_in
- fail_combo  out  4  sticky per-combination flags, bit index c = {a_out, b_out}

## Operation
- States: IDLE, WAIT, SAMPLE.
- Combination index c is 2 bits and steps 0, 1, 2, 3; {a_out, b_out} = c.
- Expected gate_in per c:
  - c = 0: 6'h2C
  - c = 1: 6'h16
  - c = 2: 6'h16
  - c = 3: 6'h23
- Start accepted in IDLE:
  - err_mask, fail_combo and pass cleared; c = 0; {a_out, b_out} = 00.
  - busy = 1; settle counter = SETTLE_CYCLES; go to WAIT.
- WAIT: counter decrements each edge. The edge where the counter equals 1 moves to SAMPLE.
- SAMPLE edge: mismatch m = gate_in ^ expected(c).
  - err_mask |= m.
  - fail_combo[c] set if m is nonzero.
  - If c < 3: c increments, a_out/b_out update, counter reloads, go to WAIT.
  - If c = 3: go to IDLE, done = 1, busy = 0, pass = (updated err_mask == 0), {a_out, b_out} = 00.
- start while busy is ignored; there is no queueing.
- start during the done cycle is accepted, giving back-to-back sweeps.
- Out-of-range SETTLE_CYCLES is a configuration error and is caught by an elaboration-time check.

## Timing
- Reset values: a_out = 0, b_out = 0, busy = 0, done = 0, pass = 0, err_mask = 0, fail_combo = 0, state IDLE, c = 0.
- rst_n low takes effect immediately (asynchronous).
  - Mid-sweep reset aborts the sweep: no done pulse, sticky flags lost.
- All outputs are registered.
- busy rises on the accepting edge.
- Each combination occupies exactly SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in WAIT, then 1 in SAMPLE.
- gate_in is sampled at the closing edge of the SAMPLE cycle.
  - gate_in is therefore stable for at least SETTLE_CYCLES full cycles after a_out/b_out change.
- done rises on edge 4·(SETTLE_CYCLES+1) after the accepting edge and falls on the next edge.
  - busy falls and pass updates on that same edge.
- Throughput: one sweep per 4·(SETTLE_CYCLES+1) cycles when start is held high continuously.

## Structure
- Package gate_chk_pkg holds:
  - gate bit-index constants (AND_B = 0 … XNOR_B = 5);
  - NUM_GATES = 6 and NUM_COMBOS = 4;
  - the state enum;
  - the 4-entry expected-vector constant table.
- One natural sub-module, gate_expect: combinational, 2-bit c in, 6-bit expected vector out, built from the package table.
- Settle counter and FSM stay in the top module.

## Test plan
- Golden run: SETTLE_CYCLES = 1, correct gate model on gate_in, single start pulse.
  - a_out/b_out go 00, 01, 10, 11, each held 2 cycles.
  - done exactly 8 edges after the accepting edge.
  - pass = 1, err_mask = 0, fail_combo = 0.
- Stuck-at fault: xor bit forced to 0 -> err_mask = 6'b010000, fail_combo = 4'b0110, pass = 0.
- Start handling:
  - start re-pulsed 3 cycles into a sweep is ignored; done timing is unchanged.
  - start held high in the done cycle launches a new sweep; err_mask clears on that edge.
- Reset mid-sweep: rst_n low during combination 2 -> all outputs 0 immediately and no done pulse. A following start then completes with pass = 1.
- Settle window, SETTLE_CYCLES = 3:
  - gate model with 2-cycle output delay -> pass = 1, done at edge 16.
  - model delay 4 cycles -> pass = 0, fail_combo nonzero.
